wm_insert_pipe: RTL

Parametrised, pipelined watermark-insertion datapath for the image-watermarking FPGA design. Each beat carries one host pixel, three neighbour pixels and a 2-bit watermark symbol. The block computes a weighted blend of the host pixel and the neighbour average, using run-time programmable coefficients. It sits between the pixel-window fetch and the frame writer, with valid/ready flow control on both sides and a count of embedded pixels.

---
 rtl/wm_insert_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wm_insert_pipe.sv
// wm_insert_pipe: 3-stage watermark blend of a host pixel with its neighbour
// average, using run-time coefficients, valid/ready flow control and a saturating counter.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        input beat handshake
//   host_px, nb_l/c/r        host pixel and left/centre/right neighbours
//   wm_sym                   2-bit symbol (01/10 blend, 00/11 bypass)
//   out_valid/out_ready      output beat handshake
//   out_px                   watermarked pixel
//   cfg_we/cfg_ready         coefficient write, accepted only when drained
//   cfg_coef_a/b/c           new coefficients
//   cnt_clr, wm_cnt          clear and count of modified pixels delivered
// Build option: define WM_SAT_EN to saturate the blend, else it wraps.
`timescale 1ns/1ps
module wm_insert_pipe #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  host_px,
    input  logic [PIX_W-1:0]  nb_l,
    input  logic [PIX_W-1:0]  nb_c,
    input  logic [PIX_W-1:0]  nb_r,
    input  logic [1:0]        wm_sym,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_px,
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic [COEF_W-1:0] cfg_coef_a,
    input  logic [COEF_W-1:0] cfg_coef_b,
    input  logic [COEF_W-1:0] cfg_coef_c,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  wm_cnt
);

    localparam int PW = PIX_W + COEF_W;
    localparam int SW = PW + 1;

    localparam logic [COEF_W-1:0] AB_RST =
        {1'b1, {(COEF_W-1){1'b0}}};
    localparam logic [COEF_W-1:0] C_RST =
        {2'b01, {(COEF_W-2){1'b0}}};
    localparam logic [SW-1:0] RND =
        {{(PIX_W+1){1'b0}}, 1'b1, {(COEF_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE =
        {{(CNT_W-1){1'b0}}, 1'b1};

    logic              v1, v2, v3;
    logic              stall, cfg_go, accept;
    logic [COEF_W-1:0] coef_a, coef_b, coef_c;

    logic [PIX_W:0]    lr, mid;
    logic [PIX_W-1:0]  nb1, host1;
    logic [1:0]        sym1;

    logic [COEF_W-1:0] k;
    logic [PW-1:0]     pa_d, pm_d, pa2, pm2;
    logic [PIX_W-1:0]  host2;
    logic [1:0]        sym2;

    logic [SW-1:0]     sum;
    logic [PIX_W:0]    s;
    logic [PIX_W-1:0]  blend;
    logic              mod2, mod3, fire;
    logic              unused_bits;

    // A stalled output freezes the whole pipe.
    assign stall     = v3 & ~out_ready;
    assign cfg_ready = ~v1 & ~v2 & ~v3 & ~in_valid;
    assign cfg_go    = cfg_we & cfg_ready;
    assign in_ready  = ~stall & ~cfg_go;
    assign accept    = in_valid & in_ready;
    assign out_valid = v3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_a <= AB_RST;
            coef_b <= AB_RST;
            coef_c <= C_RST;
        end else if (cfg_go) begin
            coef_a <= cfg_coef_a;
            coef_b <= cfg_coef_b;
            coef_c <= cfg_coef_c;
        end
    end

    // Neighbour average with one carry bit per add, never overflowing.
    assign lr  = {1'b0, nb_l} + {1'b0, nb_r};
    assign mid = {1'b0, lr[PIX_W:1]} + {1'b0, nb_c};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            nb1   <= '0;
            host1 <= '0;
            sym1  <= '0;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                nb1   <= mid[PIX_W:1];
                host1 <= host_px;
                sym1  <= wm_sym;
            end
        end
    end

    always_comb begin
        k = '0;
        unique case (1'b1)
            sym1 == 2'b01: k = coef_c;
            sym1 == 2'b10: k = coef_b;
            default:       k = '0;
        endcase
    end

    assign pa_d = {{COEF_W{1'b0}}, nb1} * {{PIX_W{1'b0}}, coef_a};
    assign pm_d = {{COEF_W{1'b0}}, host1} * {{PIX_W{1'b0}}, k};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            pa2   <= '0;
            pm2   <= '0;
            host2 <= '0;
            sym2  <= '0;
        end else if (!stall) begin
            v2 <= v1;
            if (v1) begin
                pa2   <= pa_d;
                pm2   <= pm_d;
                host2 <= host1;
                sym2  <= sym1;
            end
        end
    end

    // Round half-up, then drop the fraction bits.
    assign sum  = {1'b0, pa2} + {1'b0, pm2} + RND;
    assign s    = sum[SW-1:COEF_W];
    assign mod2 = sym2[0] ^ sym2[1];

`ifdef WM_SAT_EN
    assign blend = s[PIX_W] ? {PIX_W{1'b1}} : s[PIX_W-1:0];
`else
    assign blend = s[PIX_W-1:0];
`endif

    assign unused_bits = ^{sum[COEF_W-1:0], s[PIX_W], lr[0], mid[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3     <= 1'b0;
            out_px <= '0;
            mod3   <= 1'b0;
        end else if (!stall) begin
            v3 <= v2;
            if (v2) begin
                out_px <= mod2 ? blend : host2;
                mod3   <= mod2;
            end
        end
    end

    assign fire = v3 & out_ready & mod3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wm_cnt <= '0;
        end else if (cnt_clr) begin
            wm_cnt <= '0;
        end else if (fire && (wm_cnt != {CNT_W{1'b1}})) begin
            wm_cnt <= wm_cnt + CNT_ONE;
        end
    end

endmodule
